bg_line_merge: RTL and testbench
================================

Name: bg_line_merge

Overview:
Downstream consumer of the BG data formatter's 20-bit formatted pixel words. Merges pixels from all enabled backgrounds, arriving one per cycle in any BG order, into a single-scanline buffer of WIDTH entries. Each buffer entry keeps the front-most visible pixel. A registered read port lets the downstream BG/OBJ compositor fetch the winner for each x.

Parameters:
WIDTH, 240, number of pixels per scanline (buffer depth)
XW, 8, width of x coordinates; must satisfy 2**XW >= WIDTH

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
line_start  in  1  one-cycle pulse; (re)starts buffer clear for a new scanline
in_valid  in  1  formatted pixel present on in_x/in_formatted
in_ready  out  1  block accepts a pixel this cycle; transfer = in_valid & in_ready
in_x  in  XW  pixel x coordinate
in_formatted  in  20  {priority[19:18], 0, bitmapped[16], visible[15], payload[14:0]}
busy  out  1  high while clearing or while a merge is in flight
rd_x  in  XW  read address
rd_data  out  20  registered buffer entry at rd_x, valid one cycle after rd_x

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=0, busy=0, rd_data=20'h0, pipeline valid bits cleared, clear counter=0. Buffer contents are undefined until the first clear.
- States:
  - IDLE: in_ready=0. line_start -> CLEAR.
  - CLEAR: writes 20'h0 to entry cnt, cnt increments each cycle; in_ready=0, busy=1. After writing entry WIDTH-1 -> MERGE. Total clear time is exactly WIDTH cycles.
  - MERGE: in_ready=1; busy=1 only while the write pipeline holds a valid entry.
- line_start in any state (including mid-CLEAR or MERGE): flush the pipeline, discard any in-flight write, set cnt=0, enter CLEAR next cycle. line_start has priority over an in_valid transfer in the same cycle; that pixel is dropped.
- Merge pipeline, 2 stages:
  - S1 (accept cycle): read mem[in_x]; register the pixel and in_x.
  - S2: compare against the old entry and write the winner back. Throughput is 1 pixel/cycle.
- Effective BG number: 2 if bitmapped (bit16) = 1, else payload[10:9].
- New pixel wins iff new.visible AND (old.visible=0 OR new.pri < old.pri OR (new.pri == old.pri AND new.bg < old.bg)). On an exact tie the old entry is kept.
- Writes only on a win. Invisible pixels are accepted, then dropped.
- in_x >= WIDTH: accepted, no read side effect, no write.
- Hazard: if the S1 x equals the x being written in S2 the same cycle, S1 uses the S2 winner (forwarding), not the stale memory value. Back-to-back same-x pixels must merge correctly with no stall.
- Read port: rd_data <= mem[rd_x] each cycle in every state. On a collision with a same-cycle write, rd_data returns the pre-write value. rd_x >= WIDTH returns 20'h0.
- The formatted word is stored unmodified; bit17 is passed through.

Decomposition:
- Shared gfx package holds:
  - field position constants: PRI_HI=19, PRI_LO=18, BMP_BIT=16, VIS_BIT=15, BGNO_HI=10, BGNO_LO=9
  - the 20-bit formatted_pixel_t typedef
  - state enum {IDLE, CLEAR, MERGE}
- One sub-module: bg_pixel_win, combinational compare (old, new) -> take_new. It is reused by the OBJ merge stage.
- The buffer is an inferred dual-port RAM kept in the top module.

Test Plan:
- Reset, then line_start -> busy=1, in_ready=0 for exactly 240 cycles, then in_ready=1. Reading all x returns 20'h0.
- x=5: BG1 pri2 (word 20'h88205), then BG0 pri1 pal 0x33 -> rd_x=5 gives BG0 word 20'h48033. Then BG3 pri0 invisible -> entry unchanged.
- Back-to-back x=7: BG2 pri3 visible, then BG1 pri3 visible -> BG1 entry wins (forwarding). Same cycle pair with BG3 pri3 on the second beat -> BG2 kept.
- Equal priority and BG tie (BG1 pri1 sent twice, different payloads) -> first payload retained. Bitmapped pri0 vs BG1 pri0 -> BG1 wins (bg 1 < 2).
- in_x=240 with a visible pixel -> no entry changes. Simultaneous rd_x=9 and a winning write to x=9 -> rd_data shows the old value, then the new value next read.
- line_start asserted 100 cycles into CLEAR, and again with a pixel in S2 -> the clear restarts (240 further cycles) and the in-flight pixel never appears. Async reset mid-MERGE -> in_ready=0 and rd_data=0 immediately.

Source files
------------

// File: rtl/bg_line_merge_pkg.sv
// Shared gfx definitions for the BG line merge stage.
// Field positions, pixel word type and merge FSM states.
package bg_line_merge_pkg;

  localparam int PRI_HI  = 19;
  localparam int PRI_LO  = 18;
  localparam int BMP_BIT = 16;
  localparam int VIS_BIT = 15;
  localparam int BGNO_HI = 10;
  localparam int BGNO_LO = 9;

  typedef logic [19:0] formatted_pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    MERGE
  } state_t;

  // Compact ordering key: {visible, priority, effective bg}
  typedef logic [4:0] win_key_t;

  function automatic win_key_t key_of(formatted_pixel_t p);
    logic [1:0] bg;
    bg = p[BMP_BIT] ? 2'd2 : p[BGNO_HI:BGNO_LO];
    return {p[VIS_BIT], p[PRI_HI:PRI_LO], bg};
  endfunction

endpackage

// File: rtl/bg_pixel_win.sv
// Front-most pixel decision between a stored and an incoming pixel.
// Shared with the OBJ merge stage; works on ordering keys only.
module bg_pixel_win (
  input  logic [4:0] old_key,
  input  logic [4:0] new_key,
  output logic       take_new
);

  logic       old_vis;
  logic       new_vis;
  logic [1:0] old_pri;
  logic [1:0] new_pri;
  logic [1:0] old_bg;
  logic [1:0] new_bg;

  assign {old_vis, old_pri, old_bg} = old_key;
  assign {new_vis, new_pri, new_bg} = new_key;

  // Exact ties keep the stored pixel.
  always_comb begin
    take_new = 1'b0;
    if (new_vis) begin
      take_new = !old_vis
               || (new_pri < old_pri)
               || ((new_pri == old_pri) && (new_bg < old_bg));
    end
  end

endmodule

// File: rtl/bg_line_merge.sv
// Scanline buffer merging formatted BG pixels, front-most wins.
// Two-stage read/compare/write pipeline with S2->S1 forwarding.
module bg_line_merge #(
  parameter int WIDTH = 240,
  parameter int XW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          line_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [19:0]   in_formatted,
  output logic          busy,
  input  logic [XW-1:0] rd_x,
  output logic [19:0]   rd_data
);

  import bg_line_merge_pkg::*;

  localparam logic [XW:0]   WLIM = (XW+1)'(WIDTH);
  localparam logic [XW-1:0] LAST = XW'(WIDTH-1);

  state_t           state;
  state_t           state_nx;
  logic [XW-1:0]    cnt;
  logic             clr_we;

  logic             acc;
  logic             in_ok;
  logic             rd_ok;
  logic             p_ok;

  logic             p_valid;
  logic [XW-1:0]    p_x;
  formatted_pixel_t p_pix;
  win_key_t         p_old;
  win_key_t         s1_old;
  logic             p_win;
  logic             wr_merge;

  logic             wr_en;
  logic [XW-1:0]    wr_addr;
  formatted_pixel_t wr_data;

  formatted_pixel_t mem [WIDTH];

  assign in_ok = {1'b0, in_x} < WLIM;
  assign rd_ok = {1'b0, rd_x} < WLIM;
  assign p_ok  = {1'b0, p_x} < WLIM;

  // FSM next state and per-state outputs; line_start always restarts the clear.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    clr_we   = 1'b0;
    unique case (state)
      IDLE: state_nx = IDLE;
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt == LAST) state_nx = MERGE;
      end
      MERGE: begin
        in_ready = 1'b1;
        busy     = p_valid;
      end
      default: state_nx = IDLE;
    endcase
    if (line_start) begin
      state_nx = CLEAR;
      clr_we   = 1'b0;
    end
  end

  // State register and clear address counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (line_start) begin
        cnt <= '0;
      end else if (state == CLEAR) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  assign acc = in_valid && in_ready && !line_start;

  bg_pixel_win u_win (
    .old_key  (p_old),
    .new_key  (key_of(p_pix)),
    .take_new (p_win)
  );

  assign wr_merge = p_valid && p_win && p_ok && !line_start;

  // A same-x pixel in S2 lands after this read, so bypass its winner.
  assign s1_old = (wr_merge && (p_x == in_x)) ? key_of(p_pix)
                : (in_ok ? key_of(mem[in_x]) : '0);

  assign wr_en   = clr_we || wr_merge;
  assign wr_addr = clr_we ? cnt : p_x;
  assign wr_data = clr_we ? '0 : p_pix;

  // S1 register: accepted pixel, its x and the current entry's key.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_x     <= '0;
      p_pix   <= '0;
      p_old   <= '0;
    end else begin
      p_valid <= acc;
      if (acc) begin
        p_x   <= in_x;
        p_pix <= in_formatted;
        p_old <= s1_old;
      end
    end
  end

  // Single write port shared by the clear sweep and merge winners.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, read-before-write on collisions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_ok ? mem[rd_x] : '0;
    end
  end

endmodule

// File: tb/tb_bg_line_merge.sv
// Directed bench for bg_line_merge with a read-response scoreboard.
// Reads push expectations; a monitor pops and compares rd_data.
module tb_bg_line_merge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [19:0] in_formatted = '0;
  logic        busy;
  logic [7:0]  rd_x = '0;
  logic [19:0] rd_data;

  always #5 clock = ~clock;

  bg_line_merge #(.WIDTH(240), .XW(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .line_start   (line_start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_formatted (in_formatted),
    .busy         (busy),
    .rd_x         (rd_x),
    .rd_data      (rd_data)
  );

  typedef struct packed {
    logic [7:0]  x;
    logic [19:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_pend;
  logic rd_req = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Monitor: one cycle after a requested read, compare rd_data.
  always @(posedge clock) begin
    mon_pend = rd_req;
    #1;
    if (mon_pend && !reset) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected got=%0h want=none", rd_data);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("rd_x=%0d", mon_e.x), rd_data, mon_e.d);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic px(input logic [7:0] x, input logic [19:0] w);
    in_x = x;
    in_formatted = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] x, input logic [19:0] e);
    rd_x = x;
    rd_req = 1'b1;
    sb.push_back('{x: x, d: e});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic clr_wait(input string nm);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (!in_ready && n < 1000) begin
      if (!busy) bad++;
      tick();
      n++;
    end
    chk({nm, "_cycles"}, n, 240);
    chk({nm, "_busy"}, bad, 0);
  endtask

  initial begin
    tick(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 0);

    pulse_ls();
    clr_wait("clear");
    chk("merge_busy_idle", busy, 0);
    for (int i = 0; i < 240; i++) rd(8'(i), 20'h0);
    rd(8'd240, 20'h0);
    rd(8'd255, 20'h0);

    px(8'd5, 20'h88205);
    chk("busy_inflight", busy, 1);
    tick();
    chk("busy_drained", busy, 0);
    tick();
    rd(8'd5, 20'h88205);
    px(8'd5, 20'h48033);
    tick(2);
    rd(8'd5, 20'h48033);
    px(8'd5, 20'h00600);
    tick(2);
    rd(8'd5, 20'h48033);

    px(8'd7, 20'hC8400);
    px(8'd7, 20'hC8200);
    px(8'd8, 20'hC8400);
    px(8'd8, 20'hC8600);
    px(8'd10, 20'h48201);
    px(8'd10, 20'h48202);
    px(8'd11, 20'h19234);
    px(8'd11, 20'h08211);
    px(8'd14, 20'h08211);
    px(8'd14, 20'h19234);
    px(8'd12, 20'hA8001);
    px(8'd13, 20'h00600);
    px(8'd15, 20'hC8400);
    px(8'd15, 20'hC8600);
    px(8'd15, 20'h88205);
    px(8'd240, 20'h48033);
    tick(2);
    rd(8'd7, 20'hC8200);
    rd(8'd8, 20'hC8400);
    rd(8'd10, 20'h48201);
    rd(8'd11, 20'h08211);
    rd(8'd14, 20'h08211);
    rd(8'd12, 20'hA8001);
    rd(8'd13, 20'h00000);
    rd(8'd15, 20'h88205);
    rd(8'd0, 20'h0);
    rd(8'd239, 20'h0);
    rd(8'd240, 20'h0);

    px(8'd9, 20'h88205);
    tick(2);
    px(8'd9, 20'h48033);
    rd(8'd9, 20'h88205);
    rd(8'd9, 20'h48033);

    px(8'd20, 20'h48033);
    pulse_ls();
    clr_wait("restart_s2");
    rd(8'd20, 20'h0);
    rd(8'd5, 20'h0);

    pulse_ls();
    tick(100);
    pulse_ls();
    clr_wait("restart_mid");

    px(8'd30, 20'h48033);
    tick(2);
    rd(8'd30, 20'h48033);
    tick(2);
    chk("sb_drained", sb.size(), 0);
    chk("pre_rst_rd_data", rd_data, 20'h48033);
    chk("pre_rst_in_ready", in_ready, 1);

    #2 reset = 1'b1;
    #1;
    chk("async_in_ready", in_ready, 0);
    chk("async_rd_data", rd_data, 0);
    chk("async_busy", busy, 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
